// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: key codes, password
// length and the controller FSM state encoding.
package lock_pkg;

    localparam logic [3:0] KEY_LOCK  = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam int         PWD_LEN   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// Keypad strobe interface: one-cycle key_valid qualifying a 4-bit key_code.
interface lock_ctrl_if;

    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        output key_valid,
        output key_code
    );

    modport slave (
        input key_valid,
        input key_code
    );

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter; o_done flags the last cycle of a loaded interval.
module lockout_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    // Done on the count of one so a load of N yields exactly N enabled cycles.
    assign o_done = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller driving a downstream NAND RS latch with Sn/Rn pulses.
// Optional lockout after three wrong codes is enabled by LOCK_CTRL_LOCKOUT_EN.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [15:0] PWD            = 16'h1155,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    lock_ctrl_if.slave        key_if,
    output logic              Sn,
    output logic              Rn,
    output logic [2:0]        digit_cnt,
    output logic [1:0]        err_cnt,
    output logic              lockout
);

    localparam logic [2:0] CNT_FULL = 3'(PWD_LEN);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_entry;
    logic [15:0] w_entry_next;
    logic [2:0]  r_digit_cnt;
    logic [2:0]  w_digit_cnt_next;
    logic        r_ovf;
    logic        w_ovf_next;
    logic [1:0]  r_err_cnt;
    logic [1:0]  w_err_cnt_next;
    logic [1:0]  w_err_inc;
    logic        r_sn;
    logic        w_sn_next;
    logic        r_rn;
    logic        w_rn_next;
    logic        w_match;
    logic        w_is_digit;

`ifdef LOCK_CTRL_LOCKOUT_EN
    logic        r_lockout;
    logic        w_lockout_next;
    logic        w_timer_load;
    logic        w_timer_done;

    lockout_timer #(
        .WIDTH (16)
    ) u_lockout_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (16'(LOCKOUT_CYCLES)),
        .i_en       (r_state == ST_LOCKOUT),
        .o_done     (w_timer_done)
    );

    assign lockout = r_lockout;
`else
    logic        w_unused_cfg;

    assign w_unused_cfg = ^(16'(LOCKOUT_CYCLES));
    assign lockout      = 1'b0;
`endif

    assign w_is_digit = is_digit(key_if.key_code);
    assign w_err_inc  = (r_err_cnt == 2'd3) ? 2'd3 : (r_err_cnt + 2'd1);
    assign w_match    = (r_digit_cnt == CNT_FULL) && !r_ovf && (r_entry == PWD);

    always_comb begin
        w_state_next     = r_state;
        w_entry_next     = r_entry;
        w_digit_cnt_next = r_digit_cnt;
        w_ovf_next       = r_ovf;
        w_err_cnt_next   = r_err_cnt;
        w_sn_next        = 1'b1;
        w_rn_next        = 1'b1;
`ifdef LOCK_CTRL_LOCKOUT_EN
        w_lockout_next   = r_lockout;
        w_timer_load     = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (key_if.key_valid) begin
                    if (w_is_digit) begin
                        if (r_digit_cnt < CNT_FULL) begin
                            w_entry_next     = {r_entry[11:0], key_if.key_code};
                            w_digit_cnt_next = r_digit_cnt + 3'd1;
                            w_state_next     = ST_ENTRY;
                        end else begin
                            w_ovf_next = 1'b1;
                        end
                    end else if (key_if.key_code == KEY_ENTER) begin
                        w_entry_next     = '0;
                        w_digit_cnt_next = '0;
                        w_ovf_next       = 1'b0;
                        w_state_next     = ST_IDLE;
                        if (w_match) begin
                            w_sn_next      = 1'b0;
                            w_err_cnt_next = 2'd0;
                        end else begin
                            w_rn_next      = 1'b0;
                            w_err_cnt_next = w_err_inc;
`ifdef LOCK_CTRL_LOCKOUT_EN
                            if (w_err_inc == 2'd3) begin
                                w_state_next   = ST_LOCKOUT;
                                w_lockout_next = 1'b1;
                                w_timer_load   = 1'b1;
                            end
`endif
                        end
                    end else if (key_if.key_code == KEY_LOCK) begin
                        w_rn_next        = 1'b0;
                        w_entry_next     = '0;
                        w_digit_cnt_next = '0;
                        w_ovf_next       = 1'b0;
                        w_state_next     = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
`ifdef LOCK_CTRL_LOCKOUT_EN
                // Keys are dropped here; only the timer moves us out.
                if (w_timer_done) begin
                    w_state_next   = ST_IDLE;
                    w_lockout_next = 1'b0;
                    w_err_cnt_next = 2'd0;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Reset holds Rn low so the latch is forced closed while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_entry     <= '0;
            r_digit_cnt <= '0;
            r_ovf       <= 1'b0;
            r_err_cnt   <= '0;
            r_sn        <= 1'b1;
            r_rn        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_entry     <= w_entry_next;
            r_digit_cnt <= w_digit_cnt_next;
            r_ovf       <= w_ovf_next;
            r_err_cnt   <= w_err_cnt_next;
            r_sn        <= w_sn_next;
            r_rn        <= w_rn_next;
        end
    end

`ifdef LOCK_CTRL_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockout <= 1'b0;
        end else begin
            r_lockout <= w_lockout_next;
        end
    end
`endif

    assign Sn        = r_sn;
    assign Rn        = r_rn;
    assign digit_cnt = r_digit_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter PWD, default 16'h1155: four BCD digits of the password, most-significant nibble entered first.
REQ-002 Parameter LOCKOUT_CYCLES, default 1000: lockout duration in clk cycles; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-006 key_code  input  4  0-9 digit, 4'hC LOCK, 4'hE ENTER; all other codes ignored.
REQ-007 Sn  output  1  active-low set pulse to the downstream NAND RS latch (opens the lock).
REQ-008 Rn  output  1  active-low reset pulse to the downstream NAND RS latch (closes the lock).
REQ-009 digit_cnt  output  3  digits captured in the current entry, 0..4.
REQ-010 err_cnt  output  2  consecutive wrong ENTERs, saturating at 3.
REQ-011 lockout  output  1  high while keys are being ignored.

Function
REQ-012 FSM states are IDLE (no digits), ENTRY (1..4 digits), and LOCKOUT; Sn and Rn are registered outputs.
REQ-013 A digit in IDLE or ENTRY with digit_cnt<4: shift it into the 16-bit entry register LSB-first nibble, increment digit_cnt, and go to ENTRY.
REQ-014 A digit with digit_cnt==4: set the sticky overflow flag; leave the entry and digit_cnt unchanged.
REQ-015 ENTER with digit_cnt==4, no overflow, and entry==PWD is a match: Sn=0 for exactly the next cycle, err_cnt cleared.
REQ-016 Any other ENTER is a mismatch: Rn=0 for exactly the next cycle, err_cnt incremented, saturating at 3.
REQ-017 LOCK: Rn=0 for exactly the next cycle; err_cnt unchanged.
REQ-018 After any ENTER or LOCK, clear the entry, digit_cnt, and overflow, and return to IDLE (or to LOCKOUT per REQ-025).
REQ-019 Outside pulse cycles, Sn=1 and Rn=1.
REQ-020 Sn and Rn are never both 0 in the same cycle, since that is the forbidden NAND latch input.
REQ-021 Back-to-back key strobes are each processed, so consecutive commands produce consecutive single-cycle pulses.
REQ-022 Ignored codes and cycles without key_valid leave all state unchanged.

Reset
REQ-023 While rst=1: Sn=1, Rn=0 (forces the latch closed), state=IDLE, and entry, digit_cnt, overflow, err_cnt, lockout timer, and lockout are all 0.
REQ-024 In the first cycle after rst falls, Rn=1; rst asserted mid-entry or mid-lockout discards all progress.

Configuration
REQ-025 With LOCK_CTRL_LOCKOUT_EN defined:
- a mismatch that brings err_cnt to 3 enters LOCKOUT the next cycle, with lockout=1;
- key strobes are ignored for exactly LOCKOUT_CYCLES cycles;
- on exit the FSM goes to IDLE with lockout=0 and err_cnt=0;
- the Rn pulse of the triggering mismatch is still issued.
REQ-026 Without LOCK_CTRL_LOCKOUT_EN: the LOCKOUT state and timer are absent, lockout is tied to 0, and err_cnt only saturates.

Structure
REQ-027 Package lock_pkg holds the key code constants (KEY_LOCK, KEY_ENTER), PWD_LEN=4, and the FSM state enum.
REQ-028 Sub-module lockout_timer (16-bit down-counter with load/done) is instantiated only under LOCK_CTRL_LOCKOUT_EN.

Verification
REQ-029 Reset, then keys 1,1,5,5,ENTER -> Sn=0 for exactly one cycle after ENTER, Rn stays 1, err_cnt=0.
REQ-030 Keys 1,1,5,4,ENTER -> Rn=0 for one cycle, err_cnt=1; then 1,1,5,5,ENTER -> Sn pulse, err_cnt=0.
REQ-031 Keys 1,1,5,5,9,ENTER (overflow) -> Rn pulse, digit_cnt returns to 0; ENTER with 3 digits -> Rn pulse.
REQ-032 With macro and LOCKOUT_CYCLES=20: three wrong ENTERs -> lockout=1 for 20 cycles; a correct code entered during lockout -> no Sn pulse; after exit, the correct code -> Sn pulse.
REQ-033 ENTER (match) and LOCK on consecutive cycles -> Sn low in cycle n+1, Rn low in cycle n+2, never both low together.
REQ-034 rst pulsed after 2 digits -> Rn=0 during reset, digit_cnt=0; then 1,1,5,5,ENTER -> Sn pulse.
